// File: rtl/vx_gbar_arb.sv
// vx_gbar_arb: merges per-requester global-barrier requests onto one gbar bus
// with round-robin arbitration and a 2-entry registered output buffer, and
// routes each barrier release back only to the requesters waiting on that id.
//
// Handshake rule used on every interface: a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holds valid and its data
// stable until the transfer, and ready never depends on the same interface's
// valid through anything but the arbiter grant.
module vx_gbar_arb #(
    parameter int NUM_REQS = 4,
    parameter int NB_WIDTH = 4,
    parameter int NC_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid_in,
    input  logic [NUM_REQS*NB_WIDTH-1:0] req_id_in,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1_in,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id_in,
    output logic [NUM_REQS-1:0]          req_ready_in,
    output logic                         req_valid_out,
    output logic [NB_WIDTH-1:0]          req_id_out,
    output logic [NC_WIDTH-1:0]          req_size_m1_out,
    output logic [NC_WIDTH-1:0]          req_core_id_out,
    input  logic                         req_ready_out,
    input  logic                         rsp_valid_in,
    input  logic [NB_WIDTH-1:0]          rsp_id_in,
    output logic [NUM_REQS-1:0]          rsp_valid_out,
    output logic [NB_WIDTH-1:0]          rsp_id_out
);

    localparam int IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int NUM_IDS = 1 << NB_WIDTH;

    // Round-robin pointer: the requester index that has priority this cycle.
    logic [IDX_W-1:0]    r_rr_ptr;

    // Output buffer: head entry drives the outputs directly, tail is overflow.
    logic [1:0]          r_count;
    logic [NB_WIDTH-1:0] r_h_id;
    logic [NC_WIDTH-1:0] r_h_size;
    logic [NC_WIDTH-1:0] r_h_core;
    logic [IDX_W-1:0]    r_h_src;
    logic [NB_WIDTH-1:0] r_t_id;
    logic [NC_WIDTH-1:0] r_t_size;
    logic [NC_WIDTH-1:0] r_t_core;
    logic [IDX_W-1:0]    r_t_src;

    // Per-barrier-id mask of requesters waiting for a release.
    logic [NUM_REQS-1:0] r_waiting [NUM_IDS];
    logic [NUM_REQS-1:0] r_rsp_valid;
    logic [NB_WIDTH-1:0] r_rsp_id;

    logic                w_grant_found;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_can_grant;
    logic                w_accept;
    logic                w_pop;
    logic [NUM_REQS-1:0] w_ready;
    logic [NB_WIDTH-1:0] w_in_id;
    logic [NC_WIDTH-1:0] w_in_size;
    logic [NC_WIDTH-1:0] w_in_core;
    logic [NUM_REQS-1:0] w_src_onehot;
    logic [NUM_REQS-1:0] w_wait_next [NUM_IDS];

    // Requester index reached by stepping 'off' places past 'base', wrapping.
    function automatic int wrap_idx(input int base, input int off);
        return (base + off) % NUM_REQS;
    endfunction

    // The grant never looks at req_ready_out: only the registered full state gates it.
    assign w_can_grant = (r_count != 2'd2) && !reset;
    assign w_accept    = w_grant_found && w_can_grant;
    assign w_pop       = (r_count != 2'd0) && req_ready_out;

    // Find the first valid requester at or after the round-robin pointer.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!w_grant_found && req_valid_in[IDX_W'(wrap_idx(int'(r_rr_ptr), k))]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = IDX_W'(wrap_idx(int'(r_rr_ptr), k));
            end
        end
    end

    // One-hot accept back to the granted requester only.
    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_in_id   = req_id_in[w_grant_idx*NB_WIDTH +: NB_WIDTH];
    assign w_in_size = req_size_m1_in[w_grant_idx*NC_WIDTH +: NC_WIDTH];
    assign w_in_core = req_core_id_in[w_grant_idx*NC_WIDTH +: NC_WIDTH];

    // Advance the round-robin pointer past each accepted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
    end

    // Two-entry buffer: refill head on push-into-empty or push+pop, else spill to tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_h_id   <= '0;
            r_h_size <= '0;
            r_h_core <= '0;
            r_h_src  <= '0;
            r_t_id   <= '0;
            r_t_size <= '0;
            r_t_core <= '0;
            r_t_src  <= '0;
        end else begin
            if (w_accept && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                r_h_id   <= w_in_id;
                r_h_size <= w_in_size;
                r_h_core <= w_in_core;
                r_h_src  <= w_grant_idx;
            end else if (w_accept && (r_count == 2'd1)) begin
                r_t_id   <= w_in_id;
                r_t_size <= w_in_size;
                r_t_core <= w_in_core;
                r_t_src  <= w_grant_idx;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_h_id   <= r_t_id;
                r_h_size <= r_t_size;
                r_h_core <= r_t_core;
                r_h_src  <= r_t_src;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_src_onehot = NUM_REQS'(1) << r_h_src;

    // Next waiting masks: a release clears the old mask, then a handshake adds its bit.
    always_comb begin
        for (int i = 0; i < NUM_IDS; i++) begin
            w_wait_next[i] = r_waiting[i];
            if (rsp_valid_in && (rsp_id_in == NB_WIDTH'(i))) begin
                w_wait_next[i] = '0;
            end
            if (w_pop && (r_h_id == NB_WIDTH'(i))) begin
                w_wait_next[i] = w_wait_next[i] | w_src_onehot;
            end
        end
    end

    // Waiting-map registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                r_waiting[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                r_waiting[i] <= w_wait_next[i];
            end
        end
    end

    // Registered release: pulse the old mask for one cycle, id holds between releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_id    <= '0;
        end else if (rsp_valid_in) begin
            r_rsp_valid <= r_waiting[rsp_id_in];
            r_rsp_id    <= rsp_id_in;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign req_ready_in    = w_ready;
    assign req_valid_out   = (r_count != 2'd0);
    assign req_id_out      = r_h_id;
    assign req_size_m1_out = r_h_size;
    assign req_core_id_out = r_h_core;
    assign rsp_valid_out   = r_rsp_valid;
    assign rsp_id_out      = r_rsp_id;

endmodule

// File: tb/tb_vx_gbar_arb.sv
// Bench for vx_gbar_arb: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_vx_gbar_arb;

  localparam int N  = 4;
  localparam int NB = 4;
  localparam int NC = 2;
  localparam int EW = 2 + NB + NC + NC;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid_in;
  logic [N*NB-1:0] req_id_in;
  logic [N*NC-1:0] req_size_m1_in;
  logic [N*NC-1:0] req_core_id_in;
  logic [N-1:0]    req_ready_in;
  logic            req_valid_out;
  logic [NB-1:0]   req_id_out;
  logic [NC-1:0]   req_size_m1_out;
  logic [NC-1:0]   req_core_id_out;
  logic            req_ready_out;
  logic            rsp_valid_in;
  logic [NB-1:0]   rsp_id_in;
  logic [N-1:0]    rsp_valid_out;
  logic [NB-1:0]   rsp_id_out;

  int n_checks = 0;
  int n_pass   = 0;

  vx_gbar_arb #(.NUM_REQS(N), .NB_WIDTH(NB), .NC_WIDTH(NC)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_in    (req_valid_in),
    .req_id_in       (req_id_in),
    .req_size_m1_in  (req_size_m1_in),
    .req_core_id_in  (req_core_id_in),
    .req_ready_in    (req_ready_in),
    .req_valid_out   (req_valid_out),
    .req_id_out      (req_id_out),
    .req_size_m1_out (req_size_m1_out),
    .req_core_id_out (req_core_id_out),
    .req_ready_out   (req_ready_out),
    .rsp_valid_in    (rsp_valid_in),
    .rsp_id_in       (rsp_id_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_id_out      (rsp_id_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // entry packing: {src[1:0], id, size_m1, core}
  logic [EW-1:0] exp_q[$];
  logic [N-1:0]  m_wait [1<<NB];
  logic [N-1:0]  m_rsp_valid;
  logic [NB-1:0] m_rsp_id;
  int            m_rr;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_rr = 0;
      for (int i = 0; i < (1<<NB); i++) m_wait[i] = '0;
      m_rsp_valid = '0;
      m_rsp_id = '0;
      check("m_rst_valid_out", 32'(req_valid_out), 32'd0);
      check("m_rst_ready_in", 32'(req_ready_in), 32'd0);
      check("m_rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    end else begin
      bit found;
      int g;
      logic [N-1:0] exp_ready;
      logic [EW-1:0] e;
      found = 1'b0;
      g = 0;
      if (exp_q.size() < 2) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!found && req_valid_in[j]) begin
            found = 1'b1;
            g = j;
          end
        end
      end
      exp_ready = found ? (N'(1) << g) : '0;
      check("m_ready_in", 32'(req_ready_in), 32'(exp_ready));
      check("m_valid_out", 32'(req_valid_out), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("m_id_out", 32'(req_id_out), 32'(e[NB+2*NC-1 -: NB]));
        check("m_size_out", 32'(req_size_m1_out), 32'(e[2*NC-1 -: NC]));
        check("m_core_out", 32'(req_core_id_out), 32'(e[NC-1:0]));
      end
      check("m_rsp_valid", 32'(rsp_valid_out), 32'(m_rsp_valid));
      check("m_rsp_id", 32'(rsp_id_out), 32'(m_rsp_id));
      // state as it will be after the coming rising edge
      if (rsp_valid_in) begin
        m_rsp_valid = m_wait[rsp_id_in];
        m_rsp_id = rsp_id_in;
        m_wait[rsp_id_in] = '0;
      end else begin
        m_rsp_valid = '0;
      end
      if (exp_q.size() != 0 && req_ready_out) begin
        e = exp_q.pop_front();
        m_wait[e[NB+2*NC-1 -: NB]] = m_wait[e[NB+2*NC-1 -: NB]] | (N'(1) << e[EW-1 -: 2]);
      end
      if (found) begin
        exp_q.push_back({2'(g), req_id_in[g*NB +: NB], req_size_m1_in[g*NC +: NC],
                         req_core_id_in[g*NC +: NC]});
        m_rr = (g + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [NB-1:0] id,
                         input logic [NC-1:0] sz, input logic [NC-1:0] core);
    req_valid_in[i] = v;
    req_id_in[i*NB +: NB] = id;
    req_size_m1_in[i*NC +: NC] = sz;
    req_core_id_in[i*NC +: NC] = core;
  endtask

  task automatic send_rsp(input logic v, input logic [NB-1:0] id);
    rsp_valid_in = v;
    rsp_id_in = id;
  endtask

  int exp_g2[8] = '{3, 0, 1, 2, 3, 0, 1, 2};

  initial begin
    reset = 1'b1;
    req_valid_in = '0;
    req_id_in = '0;
    req_size_m1_in = '0;
    req_core_id_in = '0;
    req_ready_out = 1'b1;
    rsp_valid_in = 1'b0;
    rsp_id_in = '0;
    tick();
    tick();
    check("rst_valid_out", 32'(req_valid_out), 32'd0);
    check("rst_id_out", 32'(req_id_out), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_out), 32'd0);
    check("rst_rsp_id", 32'(rsp_id_out), 32'd0);
    reset = 1'b0;

    // 1: single request from requester 2, release routed back to it only
    set_req(2, 1'b1, 4'd3, 2'd0, 2'd2);
    settle();
    check("t1_ready_in", 32'(req_ready_in), 32'h4);
    tick();
    set_req(2, 1'b0, 4'd3, 2'd0, 2'd2);
    check("t1_valid_out", 32'(req_valid_out), 32'd1);
    check("t1_id_out", 32'(req_id_out), 32'd3);
    check("t1_core_out", 32'(req_core_id_out), 32'd2);
    tick();
    check("t1_drained", 32'(req_valid_out), 32'd0);
    send_rsp(1'b1, 4'd3);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t1_rsp_valid", 32'(rsp_valid_out), 32'h4);
    check("t1_rsp_id", 32'(rsp_id_out), 32'd3);
    tick();
    check("t1_rsp_pulse_end", 32'(rsp_valid_out), 32'd0);
    check("t1_rsp_id_hold", 32'(rsp_id_out), 32'd3);
    send_rsp(1'b1, 4'd3);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t1_rsp_cleared", 32'(rsp_valid_out), 32'd0);

    // 2: all valid, ready_out=1 -> one grant per cycle in rotating order
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(8 + i), 2'(i), 2'(i));
    for (int k = 0; k < 8; k++) begin
      settle();
      check("t2_grant", 32'(req_ready_in), 32'(1) << exp_g2[k]);
      tick();
      check("t2_valid_out", 32'(req_valid_out), 32'd1);
      check("t2_id_out", 32'(req_id_out), 32'(8 + exp_g2[k]));
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 2'd0, 2'd0);
    tick();
    check("t2_drained", 32'(req_valid_out), 32'd0);
    send_rsp(1'b1, 4'd9);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t2_rsp_valid", 32'(rsp_valid_out), 32'h2);
    tick();

    // 3: stalled output -> two entries buffered, drain in grant order
    req_ready_out = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 4'(1 + i), 2'd0, 2'(i));
    settle();
    check("t3_grant0", 32'(req_ready_in), 32'h1);
    tick();
    settle();
    check("t3_grant1", 32'(req_ready_in), 32'h2);
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t3_full_ready", 32'(req_ready_in), 32'd0);
      check("t3_hold_valid", 32'(req_valid_out), 32'd1);
      check("t3_hold_id", 32'(req_id_out), 32'd1);
      tick();
    end
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 4'd0, 2'd0, 2'd0);
    req_ready_out = 1'b1;
    settle();
    check("t3_head_first", 32'(req_id_out), 32'd1);
    tick();
    check("t3_second_id", 32'(req_id_out), 32'd2);
    check("t3_second_core", 32'(req_core_id_out), 32'd1);
    tick();
    check("t3_empty", 32'(req_valid_out), 32'd0);

    // 4: requesters 0,1,3 wait on id 5; one release pulses all three
    set_req(0, 1'b1, 4'd5, 2'd2, 2'd0);
    set_req(1, 1'b1, 4'd5, 2'd2, 2'd1);
    set_req(3, 1'b1, 4'd5, 2'd2, 2'd3);
    settle();
    check("t4_first_grant", 32'(req_ready_in), 32'h8);
    tick();
    check("t4_size_out", 32'(req_size_m1_out), 32'd2);
    tick();
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 2'd0, 2'd0);
    tick();
    tick();
    send_rsp(1'b1, 4'd5);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t4_rsp_valid", 32'(rsp_valid_out), 32'hb);
    check("t4_rsp_id", 32'(rsp_id_out), 32'd5);
    tick();
    check("t4_one_cycle", 32'(rsp_valid_out), 32'd0);

    // 5: handshake on id 7 in the same cycle as a release of id 7
    set_req(0, 1'b1, 4'd7, 2'd1, 2'd0);
    tick();
    set_req(0, 1'b0, 4'd0, 2'd0, 2'd0);
    tick();
    set_req(1, 1'b1, 4'd7, 2'd1, 2'd1);
    tick();
    set_req(1, 1'b0, 4'd0, 2'd0, 2'd0);
    send_rsp(1'b1, 4'd7);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t5_old_mask", 32'(rsp_valid_out), 32'h1);
    tick();
    send_rsp(1'b1, 4'd7);
    tick();
    send_rsp(1'b0, 4'd0);
    check("t5_new_bit", 32'(rsp_valid_out), 32'h2);

    // 6: reset with a full buffer, then first grant goes to requester 0
    req_ready_out = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'(12 + i), 2'd0, 2'(i));
    tick();
    tick();
    tick();
    check("t6_full_ready", 32'(req_ready_in), 32'd0);
    check("t6_full_id", 32'(req_id_out), 32'd14);
    reset = 1'b1;
    settle();
    check("t6_rst_valid_out", 32'(req_valid_out), 32'd0);
    check("t6_rst_ready_in", 32'(req_ready_in), 32'd0);
    check("t6_rst_id_out", 32'(req_id_out), 32'd0);
    check("t6_rst_core_out", 32'(req_core_id_out), 32'd0);
    check("t6_rst_rsp_id", 32'(rsp_id_out), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    req_ready_out = 1'b1;
    settle();
    check("t6_first_grant", 32'(req_ready_in), 32'h1);
    tick();
    check("t6_first_id", 32'(req_id_out), 32'd12);
    tick();
    tick();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd0, 2'd0, 2'd0);
    tick();
    tick();
    check("t6_drained", 32'(req_valid_out), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
